// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two ALU requesters and alu_arbiter.
//   req{0,1}_*  : operation request channels (valid/ready, operands, function)
//   rsp{0,1}_*  : per-requester result valid/ready
//   rsp_data    : captured result, shared by both response channels
// slave modport is the arbiter side; master modport is the requester side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
) ();
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_f, req1_f;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_f,
    input  req1_valid, req1_a, req1_b, req1_f,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_f,
    output req1_valid, req1_a, req1_b, req1_f,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. A granted op is registered onto alu_a/b/f, held LAT cycles,
// alu_y is captured into rsp_data and returned on the owner's response channel.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : request/response channels (slave side)
//   alu_a/b/f   : registered ALU operands/function; alu_y : ALU result
//   busy        : not idle; last_grant : most recent grantee
//   op_count    : completed operations (wrapping)
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy,
  output logic             last_grant,
  output logic [15:0]      op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d, last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
  logic [2:0]       alu_f_q, alu_f_d;
  logic [15:0]      op_count_q, op_count_d;
  logic [1:0]       req_vld, req_rdy, rsp_rdy;
  logic             gnt, rsp_done;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};

  // Lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    gnt = req_vld[1];
    if (&req_vld) gnt = ~last_grant_q;
    req_rdy = 2'b00;
    if (state_q == IDLE && !rst && |req_vld) req_rdy[gnt] = 1'b1;
  end

  assign rsp_done = (state_q == RESP) && rsp_rdy[owner_q];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_f_d      = alu_f_q;
    rsp_data_d   = rsp_data_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: if (|req_rdy) begin
        state_d      = EXEC;
        owner_d      = gnt;
        last_grant_d = gnt;
        cnt_d        = 3'(LAT);
        alu_a_d      = gnt ? bus.req1_a : bus.req0_a;
        alu_b_d      = gnt ? bus.req1_b : bus.req0_b;
        alu_f_d      = gnt ? bus.req1_f : bus.req0_f;
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        // Last hold cycle: ALU has seen stable inputs for LAT cycles.
        if (cnt_q == 3'd1) begin
          rsp_data_d = alu_y;
          state_d    = RESP;
        end
      end
      RESP: if (rsp_done) begin
        op_count_d = op_count_q + 16'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_f_q      <= 3'd0;
      rsp_data_q   <= '0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_f_q      <= alu_f_d;
      rsp_data_q   <= rsp_data_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.req0_ready = req_rdy[0];
  assign bus.req1_ready = req_rdy[1];
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.rsp_data   = rsp_data_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_f          = alu_f_q;
  assign busy           = (state_q != IDLE);
  assign last_grant     = last_grant_q;
  assign op_count       = op_count_q;
endmodule
